// File: rtl/tri_param_1r1w_byp_pkg.sv
// Shared definitions for the tri array: sequencer state encodings.
package tri_param_1r1w_byp_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } tri_state_e;

endpackage

// File: rtl/tri_array_init_ctl.sv
// Zero-fill sequencer: walks every entry once after reset, then reports ready.
module tri_array_init_ctl
    import tri_param_1r1w_byp_pkg::*;
#(
    parameter int ADDR_WIDTH    = 7,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_adr_o,
    output logic                  ready_o
);

    tri_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter parks on the last entry rather than wrapping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        case (state_q)
            INIT: begin
                if (INIT_ON_RESET != 0) begin
                    init_we_o = 1'b1;
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign init_adr_o = cnt_q;
    assign ready_o    = (state_q == READY);

endmodule

// File: rtl/tri_param_1r1w_byp.sv
// 1-read/1-write register array with bit-write enables, optional write-to-read
// forwarding and optional zero-fill after reset.
module tri_param_1r1w_byp
    import tri_param_1r1w_byp_pkg::*;
#(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 16,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_act,
    input  logic [ADDR_WIDTH-1:0] rd_adr,
    input  logic                  wr_act,
    input  logic [ADDR_WIDTH-1:0] wr_adr,
    input  logic [DATA_WIDTH-1:0] bw,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_val,
    output logic                  init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] bw_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  init_we_raw, init_we, ready;
    logic [ADDR_WIDTH-1:0] init_adr;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_stored, rd_data_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_val_q;

    tri_array_init_ctl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_ctl (
        .clk        (clk),
        .reset      (reset),
        .init_we_o  (init_we_raw),
        .init_adr_o (init_adr),
        .ready_o    (ready)
    );

    // Anything presented while reset is high is dropped, including fill writes.
    assign init_we = init_we_raw & ~reset;
    assign wr_acc  = ready & wr_act & (|bw) & ~reset;
    assign rd_acc  = ready & rd_act & ~reset;

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_adr] <= '0;
        end else if (wr_acc) begin
            mem[wr_adr] <= bw_merge(mem[wr_adr], di, bw);
        end
    end

    assign rd_stored = mem[rd_adr];

    always_comb begin
        rd_data_d = rd_stored;
        if ((BYPASS != 0) && wr_acc && (wr_adr == rd_adr)) begin
            rd_data_d = bw_merge(rd_stored, di, bw);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= '0;
            rd_val_q <= 1'b0;
        end else begin
            rd_val_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= rd_data_d;
            end
        end
    end

    assign dout      = dout_q;
    assign rd_val    = rd_val_q;
    assign init_done = ready;

endmodule

// File: tb/tb_tri_param_1r1w_byp.sv
// Directed bench: one forwarding and one non-forwarding instance share stimulus.
module tb_tri_param_1r1w_byp;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_act, wr_act;
    logic [6:0]  rd_adr, wr_adr;
    logic [15:0] bw, di;
    logic [15:0] dout1, dout0;
    logic        rd_val1, rd_val0, done1, done0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tri_param_1r1w_byp #(.ADDR_WIDTH(7), .DATA_WIDTH(16), .BYPASS(1), .INIT_ON_RESET(1)) dut_byp (
        .clk(clk), .reset(reset), .rd_act(rd_act), .rd_adr(rd_adr), .wr_act(wr_act),
        .wr_adr(wr_adr), .bw(bw), .di(di), .dout(dout1), .rd_val(rd_val1), .init_done(done1));

    tri_param_1r1w_byp #(.ADDR_WIDTH(7), .DATA_WIDTH(16), .BYPASS(0), .INIT_ON_RESET(1)) dut_nob (
        .clk(clk), .reset(reset), .rd_act(rd_act), .rd_adr(rd_adr), .wr_act(wr_act),
        .wr_adr(wr_adr), .bw(bw), .di(di), .dout(dout0), .rd_val(rd_val0), .init_done(done0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_act = 1'b0; wr_act = 1'b0; rd_adr = '0; wr_adr = '0; bw = '0; di = '0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        wr_act = 1'b1; wr_adr = a; bw = m; di = d;
    endtask

    task automatic rd(input logic [6:0] a);
        rd_act = 1'b1; rd_adr = a;
    endtask

    task automatic both(input string tag, input logic [15:0] exp_d, input logic exp_v);
        chk({tag, "_dout_byp"}, dout1, exp_d);
        chk({tag, "_dout_nob"}, dout0, exp_d);
        chk({tag, "_rdval_byp"}, {15'd0, rd_val1}, {15'd0, exp_v});
        chk({tag, "_rdval_nob"}, {15'd0, rd_val0}, {15'd0, exp_v});
    endtask

    task automatic init_window(input string tag, input bit poke);
        for (int i = 1; i <= 128; i++) begin
            idle();
            if (poke && i == 5) begin
                wr(7'd3, 16'hFFFF, 16'hBEEF);
                rd(7'd3);
            end
            step();
            chk({tag, "_done_byp"}, {15'd0, done1}, {15'd0, (i == 128)});
            chk({tag, "_done_nob"}, {15'd0, done0}, {15'd0, (i == 128)});
            if (poke && i == 5) both("init_access", 16'h0000, 1'b0);
        end
        idle();
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 128; a++) begin
            idle();
            rd(a[6:0]);
            step();
            both(tag, 16'h0000, 1'b1);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        both("reset", 16'h0000, 1'b0);
        chk("reset_done", {15'd0, done1}, 16'h0000);

        reset = 1'b0;
        init_window("init1", 1'b1);
        read_all_zero("zero1");

        // Entry 3 was written during fill and must still read zero.
        rd(7'd3); step(); both("init_wr_ignored", 16'h0000, 1'b1); idle();

        // Partial-mask overwrite.
        wr(7'd5, 16'hFFFF, 16'hA5A5); step();
        wr(7'd5, 16'h00FF, 16'h1234); step();
        chk("rdval_idle", {15'd0, rd_val1}, 16'h0000);
        idle(); rd(7'd5); step();
        both("bw_merge", 16'hA534, 1'b1);

        // Same-address read during write: forwarding vs. pre-write data.
        idle(); wr(7'd9, 16'hFFFF, 16'h0F0F); step();
        idle(); wr(7'd9, 16'hF000, 16'hFFFF); rd(7'd9); step();
        chk("same_adr_byp", dout1, 16'hFF0F);
        chk("same_adr_nob", dout0, 16'h0F0F);
        idle(); rd(7'd9); step();
        both("after_same_adr", 16'hFF0F, 1'b1);

        // Different addresses in one cycle are independent.
        idle(); wr(7'd10, 16'hFFFF, 16'h1111); rd(7'd9); step();
        both("diff_adr", 16'hFF0F, 1'b1);
        idle(); rd(7'd10); step();
        both("diff_adr_wr", 16'h1111, 1'b1);

        // An all-zero mask leaves the entry alone, even when read same cycle.
        idle(); wr(7'd10, 16'h0000, 16'hFFFF); rd(7'd10); step();
        both("bw_zero_same", 16'h1111, 1'b1);
        idle(); rd(7'd10); step();
        both("bw_zero", 16'h1111, 1'b1);

        // dout holds across idle cycles.
        idle(); wr(7'd20, 16'hFFFF, 16'h5555); step();
        idle(); rd(7'd20); step();
        both("hold_src", 16'h5555, 1'b1);
        idle();
        for (int i = 0; i < 10; i++) begin
            step();
            both("hold", 16'h5555, 1'b0);
        end

        // Reset mid-fill restarts from entry 0; accesses in the reset cycle dropped.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 60; i++) step();
        reset = 1'b1;
        wr(7'd100, 16'hFFFF, 16'hDEAD); rd(7'd20);
        step();
        both("reset_mid", 16'h0000, 1'b0);
        chk("reset_mid_done", {15'd0, done1}, 16'h0000);
        reset = 1'b0;
        init_window("init2", 1'b0);
        read_all_zero("zero2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
